// File: rtl/mem_dump_reader.sv
// Reads a run of 32-bit words from data memory and streams them out byte-wise, little-endian.
// Build option DUMP_CHECKSUM_EN appends one XOR checksum byte after the last data byte.
module mem_dump_reader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] base_word_in,
   input  logic [ADDR_W:0]   word_count_in,
   output logic [31:0]       mem_addr_out,
   output logic              mem_read_out,
   input  logic [31:0]       mem_data_in,
   output logic [7:0]        tx_data_out,
   output logic              tx_valid_out,
   input  logic              tx_ready_in,
   output logic              busy_out,
   output logic              done_out
);

   // state | meaning
   // IDLE  | waiting for start_in; base/count latched on start
   // READ  | one-cycle memory read into the shift register
   // SEND  | offering bytes 0..3 of the captured word
   // CKSUM | offering the XOR checksum byte (DUMP_CHECKSUM_EN only)
   // DONE  | one-cycle completion pulse
`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE, S_CKSUM} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

   localparam logic [ADDR_W:0]   CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] IDX_ONE = 1;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_word_idx;
   logic [ADDR_W:0]   r_remaining;
   logic [31:0]       r_shift;
   logic [1:0]        r_byte_idx;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]        r_cksum;
`endif

   logic w_xfer;
   logic w_last_byte;
   logic w_last_word;

   assign w_xfer      = tx_valid_out && tx_ready_in;
   assign w_last_byte = (r_byte_idx == 2'd3);
   assign w_last_word = (r_remaining == CNT_ONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start_in) begin
               if (word_count_in == '0) begin
`ifdef DUMP_CHECKSUM_EN
                  w_next = S_CKSUM;
`else
                  w_next = S_DONE;
`endif
               end else begin
                  w_next = S_READ;
               end
            end
         end
         S_READ: w_next = S_SEND;
         S_SEND: begin
            if (w_xfer && w_last_byte) begin
               if (w_last_word) begin
`ifdef DUMP_CHECKSUM_EN
                  w_next = S_CKSUM;
`else
                  w_next = S_DONE;
`endif
               end else begin
                  w_next = S_READ;
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         S_CKSUM: if (w_xfer) w_next = S_DONE;
`endif
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_read_out = 1'b0;
      tx_valid_out = 1'b0;
      tx_data_out  = 8'h00;
      done_out     = 1'b0;
      unique case (r_state)
         S_READ: mem_read_out = 1'b1;
         S_SEND: begin
            tx_valid_out = 1'b1;
            tx_data_out  = r_shift[7:0];
         end
`ifdef DUMP_CHECKSUM_EN
         S_CKSUM: begin
            tx_valid_out = 1'b1;
            tx_data_out  = r_cksum;
         end
`endif
         S_DONE:  done_out = 1'b1;
         default: ;
      endcase
   end

   assign busy_out     = (r_state != S_IDLE);
   assign mem_addr_out = {{(30-ADDR_W){1'b0}}, r_word_idx, 2'b00};

   // The word is shifted right on each accepted byte, so byte[idx] is always in the low lane.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word_idx  <= '0;
         r_remaining <= '0;
         r_shift     <= '0;
         r_byte_idx  <= '0;
`ifdef DUMP_CHECKSUM_EN
         r_cksum     <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_word_idx  <= base_word_in;
                  r_remaining <= word_count_in;
`ifdef DUMP_CHECKSUM_EN
                  r_cksum     <= '0;
`endif
               end
            end
            S_READ: begin
               r_shift    <= mem_data_in;
               r_byte_idx <= '0;
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_shift    <= {8'h00, r_shift[31:8]};
                  r_byte_idx <= r_byte_idx + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                  r_cksum    <= r_cksum ^ r_shift[7:0];
`endif
                  if (w_last_byte) begin
                     r_remaining <= r_remaining - CNT_ONE;
                     if (!w_last_word) r_word_idx <= r_word_idx + IDX_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: directed and randomized dumps against a queue-based model.
// Works with or without DUMP_CHECKSUM_EN defined.
module tb_mem_dump_reader;
   localparam int AW = 8;
`ifdef DUMP_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start_in;
   logic [AW-1:0] base_word_in;
   logic [AW:0]   word_count_in;
   logic [31:0]   mem_addr_out;
   logic          mem_read_out;
   logic [31:0]   mem_data_in;
   logic [7:0]    tx_data_out;
   logic          tx_valid_out;
   logic          tx_ready_in;
   logic          busy_out;
   logic          done_out;

   logic [31:0] mem [0:255];
   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   assign mem_data_in = mem[mem_addr_out[9:2]];

   mem_dump_reader #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start_in(start_in), .base_word_in(base_word_in),
      .word_count_in(word_count_in), .mem_addr_out(mem_addr_out), .mem_read_out(mem_read_out),
      .mem_data_in(mem_data_in), .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
      .tx_ready_in(tx_ready_in), .busy_out(busy_out), .done_out(done_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // mode 0: ready held high; 1: ready toggles; 2: random ready plus stray start_in while busy
   task automatic run_dump(input int base, input int count, input int mode, output logic [7:0] last_b);
      logic [7:0]  exp_b[$];
      logic [31:0] exp_a[$];
      logic [7:0]  got_b[$];
      logic [31:0] got_a[$];
      logic [7:0]  x;
      logic [31:0] w;
      logic [7:0]  pd;
      logic        pv, pr;
      int cyc, done_cyc, hold_err, busy_err, n;
      x = 8'h00; pv = 1'b0; pr = 1'b0; pd = 8'h00;
      cyc = 0; done_cyc = -1; hold_err = 0; busy_err = 0;
      for (int i = 0; i < count; i++) begin
         w = mem[(base + i) % 256];
         exp_a.push_back(32'(((base + i) % 256) * 4));
         for (int b = 0; b < 4; b++) begin
            exp_b.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
      if (CK == 1) exp_b.push_back(x);

      start_in      = 1'b1;
      base_word_in  = 8'(base);
      word_count_in = 9'(count);
      tx_ready_in   = (mode == 0);
      @(posedge clk); #1;
      start_in      = 1'b0;
      base_word_in  = 8'($urandom);
      word_count_in = 9'($urandom);
      while (done_cyc < 0 && cyc < 3000) begin
         cyc++;
         case (mode)
            0:       tx_ready_in = 1'b1;
            1:       tx_ready_in = cyc[0];
            default: begin
               tx_ready_in  = 1'($urandom_range(0, 1));
               start_in     = ($urandom_range(0, 3) == 0);
               base_word_in = 8'($urandom);
            end
         endcase
         @(negedge clk);
         if (!busy_out) busy_err++;
         if (mem_read_out) got_a.push_back(mem_addr_out);
         if (pv && !pr && (!tx_valid_out || tx_data_out !== pd)) hold_err++;
         if (tx_valid_out && tx_ready_in) got_b.push_back(tx_data_out);
         if (done_out) done_cyc = cyc;
         pv = tx_valid_out; pr = tx_ready_in; pd = tx_data_out;
         @(posedge clk); #1;
      end
      start_in    = 1'b0;
      tx_ready_in = 1'b0;

      chk("done_seen", 32'(done_cyc >= 0), 32'd1);
      chk("byte_count", 32'(got_b.size()), 32'(exp_b.size()));
      n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
      for (int i = 0; i < n; i++) chk($sformatf("byte[%0d]", i), 32'(got_b[i]), 32'(exp_b[i]));
      chk("read_count", 32'(got_a.size()), 32'(exp_a.size()));
      n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) chk($sformatf("addr[%0d]", i), got_a[i], exp_a[i]);
      chk("hold_stable", 32'(hold_err), 32'd0);
      chk("busy_during", 32'(busy_err), 32'd0);
      if (mode == 0) chk("done_cycle", 32'(done_cyc), 32'(5 * count + 1 + CK));
      last_b = (got_b.size() > 0) ? got_b[got_b.size() - 1] : 8'h00;
      // one cycle after DONE: pulse gone and any start seen during DONE was ignored
      @(negedge clk);
      chk("idle_busy", 32'(busy_out), 32'd0);
      chk("idle_done", 32'(done_out), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] lb;
      int dn;
      reset = 1'b0; start_in = 1'b0; tx_ready_in = 1'b0;
      base_word_in = '0; word_count_in = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      #12;
      chk("rst_valid", 32'(tx_valid_out), 32'd0);
      chk("rst_busy",  32'(busy_out), 32'd0);
      chk("rst_read",  32'(mem_read_out), 32'd0);
      chk("rst_done",  32'(done_out), 32'd0);
      chk("rst_data",  32'(tx_data_out), 32'd0);
      chk("rst_addr",  mem_addr_out, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      mem[3] = 32'hDDCCBBAA;
      run_dump(3, 1, 0, lb);
      run_dump(3, 1, 1, lb);
      run_dump(255, 2, 0, lb);
      run_dump(int'($urandom_range(0, 255)), 0, 0, lb);
      mem[10] = 32'h01020304;
      mem[11] = 32'h10203040;
      run_dump(10, 2, 0, lb);
`ifdef DUMP_CHECKSUM_EN
      chk("cksum_44", 32'(lb), 32'h44);
`else
      chk("last_byte_10", 32'(lb), 32'h10);
`endif

      // abort a 3-word dump while the second byte is on offer
      start_in = 1'b1; base_word_in = 8'd40; word_count_in = 9'd3; tx_ready_in = 1'b1;
      @(posedge clk); #1; start_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_valid", 32'(tx_valid_out), 32'd1);
      chk("pre_rst_byte", 32'(tx_data_out), 32'(mem[40][15:8]));
      reset = 1'b0; #1;
      chk("abort_valid", 32'(tx_valid_out), 32'd0);
      chk("abort_busy",  32'(busy_out), 32'd0);
      chk("abort_read",  32'(mem_read_out), 32'd0);
      chk("abort_data",  32'(tx_data_out), 32'd0);
      chk("abort_addr",  mem_addr_out, 32'd0);
      dn = 0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (done_out) dn++; end
      reset = 1'b1; tx_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (done_out || busy_out) dn++; end
      chk("abort_no_done", 32'(dn), 32'd0);
      @(posedge clk); #1;
      run_dump(100, 2, 0, lb);

      run_dump(int'($urandom_range(0, 255)), 256, 0, lb);
      for (int k = 0; k < 8; k++)
         run_dump(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), 2, lb);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
